// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the multi-cycle data-memory responder.
// Optional feature macro: DMEM_PARITY_EN (parity-protected storage).
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    // Data word width seen on the port.
    localparam int DMEM_WORD_W = 32;

    // Latency down-counter width; holds LATENCY-2 for LATENCY up to 15.
    localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with a synchronous write port and a registered read port.
// Optional feature macro: DMEM_PARITY_EN. When defined, each word carries an even-parity
// bit, and a read flags a mismatch on perr in the same cycle that rd updates.
// Contents are not reset; only the read registers are.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          widx,
    input  logic [DMEM_WORD_W-1:0] wd,
    input  logic                   re,
    input  logic [AW-1:0]          ridx,
    output logic [DMEM_WORD_W-1:0] rd,
    output logic                   perr
);

`ifdef DMEM_PARITY_EN
    localparam int ARR_W = DMEM_WORD_W + 1;
`else
    localparam int ARR_W = DMEM_WORD_W;
`endif

    logic [ARR_W-1:0] mem [DEPTH_WORDS];
    logic [ARR_W-1:0] wword;
    logic [ARR_W-1:0] rword;

`ifdef DMEM_PARITY_EN
    // The stored parity bit makes the XOR over all 33 bits even.
    assign wword = {^wd, wd};
`else
    assign wword = wd;
`endif

    assign rword = mem[ridx];

    // Commit write data on the edge where the write is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wword;
        end
    end

`ifdef DMEM_PARITY_EN
    // Registered read data and parity check; perr is a one-cycle flag aligned with the read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd   <= '0;
            perr <= 1'b0;
        end else if (re) begin
            rd   <= rword[DMEM_WORD_W-1:0];
            perr <= ^rword;
        end else begin
            perr <= 1'b0;
        end
    end
`else
    // Registered read data; rd holds its value until the next read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd <= '0;
        end else if (re) begin
            rd <= rword[DMEM_WORD_W-1:0];
        end
    end

    assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MEM-stage data-memory port. Accepts one read or
// write in IDLE, waits LATENCY cycles in total, then pulses ready for one cycle.
// Requests are level-held by the requester; only IDLE samples them, so a held
// request is never accepted twice.
// Optional feature macro: DMEM_PARITY_EN (parity-protected storage, see dmem_array).
//
// Handshake: MemRead/MemWrite act as a held valid; ready is a one-cycle completion
// pulse. A request is accepted on any rising edge where the FSM is IDLE and either
// request is high (write wins if both are). The requester must drop or change the
// request at the first edge after ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        misaligned,
    output logic        parity_err,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (LATENCY >= 2) ? DMEM_CNT_W'(LATENCY - 2) : '0;

    dmem_state_t           state;
    dmem_state_t           next_state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  op_write;
    logic                  mis_q;
    logic [AW-1:0]         idx_q;

    logic                  req;
    logic                  accept;
    logic [AW-1:0]         addr_idx;
    logic                  read_op;
    logic                  arr_we;
    logic                  arr_re;
    logic [AW-1:0]         arr_ridx;
    logic                  unused_addr;

    assign req      = MemRead | MemWrite;
    assign accept   = (state == DMEM_IDLE) && req;
    assign addr_idx = addr[AW+1:2];

    // Upper address bits wrap away; byte offset only feeds the misaligned flag.
    assign unused_addr = ^{addr[31:AW+2]};

    // Operation in flight: taken live from the port in IDLE, from the latch afterwards.
    assign read_op  = (state == DMEM_IDLE) ? !MemWrite : !op_write;
    assign arr_ridx = (state == DMEM_IDLE) ? addr_idx : idx_q;

    // Writes commit at acceptance; reads sample on the edge entering RESP.
    assign arr_we = rst && accept && MemWrite;
    assign arr_re = rst && read_op && (state != DMEM_RESP) && (next_state == DMEM_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DMEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            DMEM_IDLE: begin
                if (req) begin
                    next_state = (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt == '0) begin
                    next_state = DMEM_RESP;
                end
            end
            DMEM_RESP: next_state = DMEM_IDLE;
            default:   next_state = DMEM_IDLE;
        endcase
    end

    // Request latches and latency down-counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            op_write <= 1'b0;
            mis_q    <= 1'b0;
            idx_q    <= '0;
        end else if (accept) begin
            cnt      <= CNT_INIT;
            op_write <= MemWrite;
            mis_q    <= (addr[1:0] != 2'b00);
            idx_q    <= addr_idx;
        end else if ((state == DMEM_WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (arr_we),
        .widx (addr_idx),
        .wd   (wd),
        .re   (arr_re),
        .ridx (arr_ridx),
        .rd   (rd),
        .perr (parity_err)
    );

    // All status outputs derive only from registers.
    assign ready      = (state == DMEM_RESP);
    assign busy       = (state != DMEM_IDLE);
    assign misaligned = ready & mis_q;
    assign fsm_state  = state;

endmodule
